// File: rtl/auto_load_pkg.sv
// Shared types and defaults for the auto-load readback sequencer.
// The state encoding is the 4-bit debug view of the sequencer FSM.
package auto_load_pkg;

  localparam int          CNT_W_DEF     = 6;
  localparam int          TO_W_DEF      = 16;
  localparam logic [15:0] TO_CYCLES_DEF = 16'd50000;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    ENA      = 4'd1,
    RD_FIRST = 4'd2,
    W_FIRST  = 4'd3,
    CHK      = 4'd4,
    RD       = 4'd5,
    W_RD     = 4'd6,
    W_DONE   = 4'd7,
    H_CMPL   = 4'd8,
    H_ABORT  = 4'd9,
    H_TO     = 4'd10
  } al_state_e;

  // Readable state names for waveform annotation and bench messages.
  function automatic string state_name(input al_state_e s);
    case (s)
      IDLE:     return "IDLE";
      ENA:      return "ENA";
      RD_FIRST: return "RD_FIRST";
      W_FIRST:  return "W_FIRST";
      CHK:      return "CHK";
      RD:       return "RD";
      W_RD:     return "W_RD";
      W_DONE:   return "W_DONE";
      H_CMPL:   return "H_CMPL";
      H_ABORT:  return "H_ABORT";
      H_TO:     return "H_TO";
      default:  return "ILLEGAL";
    endcase
  endfunction

endpackage

// File: rtl/al_watchdog.sv
// Wait-state watchdog: counts cycles while enabled, restarting on clr.
// expired is high during the TO_CYCLES-th enabled cycle; TO_CYCLES=0 disables it.
module al_watchdog
  import auto_load_pkg::*;
#(
  parameter int              TO_W      = TO_W_DEF,
  parameter logic [TO_W-1:0] TO_CYCLES = TO_W'(TO_CYCLES_DEF)
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic ena,
  output logic expired
);

  logic [TO_W-1:0] count;
  logic [TO_W-1:0] base;
  logic [TO_W-1:0] incr;

  // clr and ena both describe the upcoming cycle, so an entry edge loads 1.
  always_comb begin
    base = clr ? '0 : count;
    incr = (base == '1) ? base : base + TO_W'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count   <= '0;
      expired <= 1'b0;
    end else if (ena) begin
      count   <= incr;
      expired <= (TO_CYCLES != '0) && (incr == TO_CYCLES);
    end else begin
      count   <= '0;
      expired <= 1'b0;
    end
  end

endmodule

// File: rtl/auto_load_seq.sv
// Auto-load sequencer: steps a latched address range issuing one EXECUTE per
// address, with early abort on AL_DONE and a watchdog on every wait state.
module auto_load_seq
  import auto_load_pkg::*;
#(
  parameter int              CNT_W     = CNT_W_DEF,
  parameter int              TO_W      = TO_W_DEF,
  parameter logic [TO_W-1:0] TO_CYCLES = TO_W'(TO_CYCLES_DEF)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [CNT_W-1:0] FIRST_ADDR,
  input  logic [CNT_W-1:0] LAST_ADDR,
  input  logic             BUSY,
  input  logic             AL_DONE,
  output logic             AL_ENA,
  output logic             CLR_AL_DONE,
  output logic             EXECUTE,
  output logic [CNT_W-1:0] AL_CNT,
  output logic             COMPLETED,
  output logic             ABORTED,
  output logic             TIMEOUT
);

  al_state_e        state, next_state;
  logic [CNT_W-1:0] cnt, first_q, last_q;
  logic             at_last;
  logic             wd_clr, wd_ena, wd_expired;
  logic             nxt_ena, nxt_clr, nxt_exec, nxt_cmpl, nxt_abort, nxt_to;

  assign at_last = (cnt >= last_q);
  assign AL_CNT  = cnt;

  al_watchdog #(.TO_W(TO_W), .TO_CYCLES(TO_CYCLES)) u_wd (
    .CLK     (CLK),
    .RST     (RST),
    .clr     (wd_clr),
    .ena     (wd_ena),
    .expired (wd_expired)
  );

  assign wd_ena = (next_state inside {W_FIRST, W_RD, W_DONE});
  assign wd_clr = (next_state != state);

  // A real wake-up (BUSY low / AL_DONE) always takes priority over expiry.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (START) next_state = ENA;
      ENA:      next_state = RD_FIRST;
      RD_FIRST: next_state = W_FIRST;
      W_FIRST: begin
        if (!BUSY)           next_state = CHK;
        else if (wd_expired) next_state = H_TO;
      end
      CHK: begin
        if (AL_DONE)      next_state = H_ABORT;
        else if (at_last) next_state = W_DONE;
        else              next_state = RD;
      end
      RD:       next_state = W_RD;
      W_RD: begin
        if (!BUSY)           next_state = at_last ? W_DONE : RD;
        else if (wd_expired) next_state = H_TO;
      end
      W_DONE: begin
        if (AL_DONE)         next_state = H_CMPL;
        else if (wd_expired) next_state = H_TO;
      end
      H_CMPL, H_ABORT, H_TO: if (!START) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_comb begin
    nxt_ena   = (next_state != IDLE);
    nxt_clr   = (next_state == ENA);
    nxt_exec  = (next_state == RD_FIRST) || (next_state == RD);
    nxt_cmpl  = (next_state == W_DONE) || (next_state == H_CMPL);
    nxt_abort = (next_state == H_ABORT);
    nxt_to    = (next_state == H_TO);
  end

  // Outputs are decoded from next_state so they line up with the state held.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      cnt         <= '0;
      first_q     <= '0;
      last_q      <= '0;
      AL_ENA      <= 1'b0;
      CLR_AL_DONE <= 1'b0;
      EXECUTE     <= 1'b0;
      COMPLETED   <= 1'b0;
      ABORTED     <= 1'b0;
      TIMEOUT     <= 1'b0;
    end else begin
      state <= next_state;
      if ((state == IDLE) && (next_state == ENA)) begin
        first_q <= FIRST_ADDR;
        last_q  <= LAST_ADDR;
      end
      // cnt < last_q whenever RD is entered, so the increment cannot wrap.
      if (next_state == RD_FIRST)                    cnt <= first_q;
      else if ((next_state == RD) && (state != RD))  cnt <= cnt + CNT_W'(1);
      AL_ENA      <= nxt_ena;
      CLR_AL_DONE <= nxt_clr;
      EXECUTE     <= nxt_exec;
      COMPLETED   <= nxt_cmpl;
      ABORTED     <= nxt_abort;
      TIMEOUT     <= nxt_to;
    end
  end

endmodule

// File: tb/tb_auto_load_seq.sv
// Directed bench for auto_load_seq: a BUSY reader model, an address
// scoreboard fed by hand-built expected ranges, and per-cycle timing checks.
module tb_auto_load_seq;
  import auto_load_pkg::*;

  localparam int          CNT_W  = 6;
  localparam int          TO_W   = 16;
  localparam logic [15:0] TO_CYC = 16'd8;
  localparam int          SEL_CMPL  = 0;
  localparam int          SEL_ABORT = 1;
  localparam int          SEL_TO    = 2;

  logic             CLK = 1'b0;
  logic             RST;
  logic             START;
  logic [CNT_W-1:0] FIRST_ADDR, LAST_ADDR;
  logic             BUSY;
  logic             AL_DONE;
  logic             AL_ENA, CLR_AL_DONE, EXECUTE;
  logic [CNT_W-1:0] AL_CNT;
  logic             COMPLETED, ABORTED, TIMEOUT;

  logic [CNT_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int exec_count = 0;
  bit saw_cmpl = 1'b0;
  int busy_len = 3;
  bit busy_stuck = 1'b0;
  int busy_left = 0;

  auto_load_seq #(.CNT_W(CNT_W), .TO_W(TO_W), .TO_CYCLES(TO_CYC)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .START       (START),
    .FIRST_ADDR  (FIRST_ADDR),
    .LAST_ADDR   (LAST_ADDR),
    .BUSY        (BUSY),
    .AL_DONE     (AL_DONE),
    .AL_ENA      (AL_ENA),
    .CLR_AL_DONE (CLR_AL_DONE),
    .EXECUTE     (EXECUTE),
    .AL_CNT      (AL_CNT),
    .COMPLETED   (COMPLETED),
    .ABORTED     (ABORTED),
    .TIMEOUT     (TIMEOUT)
  );

  // ---------------- clock / global time limit ----------------
  always #5 CLK = ~CLK;

  initial begin
    #300000;
    $display("FAIL time_limit: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "time limit");
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reader model: BUSY rises just after the EXECUTE edge and holds busy_len cycles.
  initial begin
    BUSY = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      if (busy_left > 0) busy_left--;
      if (EXECUTE) busy_left = busy_len;
      BUSY = busy_stuck || (busy_left > 0);
    end
  end

  // Scoreboard: every EXECUTE must match the next expected address.
  initial begin
    forever begin
      @(negedge CLK);
      if (COMPLETED) saw_cmpl = 1'b1;
      if (EXECUTE) begin
        exec_count++;
        check_eq("exec_expected_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check_eq("exec_addr", 32'(AL_CNT), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  function automatic logic pick(input int sel);
    case (sel)
      SEL_CMPL:  return COMPLETED;
      SEL_ABORT: return ABORTED;
      default:   return TIMEOUT;
    endcase
  endfunction

  task automatic wait_for(input string tag, input int sel, input int max_cyc);
    int n = 0;
    while (!pick(sel) && (n < max_cyc)) begin
      tick();
      n++;
    end
    check_eq({tag, "_reached"}, 32'(pick(sel)), 32'd1);
  endtask

  task automatic push_range(input int first, input int last, output int n);
    int a = first;
    exp_q.push_back(CNT_W'(a));
    n = 1;
    while (a < last) begin
      a++;
      exp_q.push_back(CNT_W'(a));
      n++;
    end
  endtask

  // Full run: start-up timing, range completion, AL_DONE hand-off, hold exit.
  task automatic do_run(input string tag, input int first, input int last);
    int n_exp;
    int base = exec_count;
    push_range(first, last, n_exp);
    FIRST_ADDR = CNT_W'(first);
    LAST_ADDR  = CNT_W'(last);
    AL_DONE    = 1'b0;
    START      = 1'b1;
    tick();
    check_eq({tag, "_ena_edge1"}, 32'(AL_ENA), 32'd1);
    check_eq({tag, "_clr_edge1"}, 32'(CLR_AL_DONE), 32'd1);
    tick();
    check_eq({tag, "_exec_edge2"}, 32'(EXECUTE), 32'd1);
    check_eq({tag, "_cnt_edge2"}, 32'(AL_CNT), 32'(first));
    check_eq({tag, "_clr_edge2"}, 32'(CLR_AL_DONE), 32'd0);
    wait_for({tag, "_completed"}, SEL_CMPL, n_exp * (busy_len + 3) + 20);
    check_eq({tag, "_exec_count"}, 32'(exec_count - base), 32'(n_exp));
    check_eq({tag, "_final_cnt"}, 32'(AL_CNT), 32'((first > last) ? first : last));
    check_eq({tag, "_no_timeout"}, 32'(TIMEOUT), 32'd0);
    AL_DONE = 1'b1;
    tick();
    check_eq({tag, "_hold_cmpl"}, 32'(COMPLETED), 32'd1);
    check_eq({tag, "_hold_ena"}, 32'(AL_ENA), 32'd1);
    START   = 1'b0;
    AL_DONE = 1'b0;
    tick();
    check_eq({tag, "_idle_ena"}, 32'(AL_ENA), 32'd0);
    check_eq({tag, "_idle_cmpl"}, 32'(COMPLETED), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int base;
    int n;
    RST = 1'b1; START = 1'b0; AL_DONE = 1'b0;
    FIRST_ADDR = '0; LAST_ADDR = '0;
    tick();
    tick();
    check_eq("rst_ena", 32'(AL_ENA), 32'd0);
    check_eq("rst_clr", 32'(CLR_AL_DONE), 32'd0);
    check_eq("rst_exec", 32'(EXECUTE), 32'd0);
    check_eq("rst_cnt", 32'(AL_CNT), 32'd0);
    check_eq("rst_cmpl", 32'(COMPLETED), 32'd0);
    check_eq("rst_abort", 32'(ABORTED), 32'd0);
    check_eq("rst_to", 32'(TIMEOUT), 32'd0);
    RST = 1'b0;
    tick();

    // Normal run over 0..33 with a 3-cycle reader.
    busy_len = 3;
    do_run("normal", 0, 33);

    // Single-address and inverted ranges: one read each.
    do_run("single", 5, 5);
    do_run("inverted", 9, 2);

    // BUSY drops on the very cycle the watchdog expires: the read proceeds.
    busy_len = 8;
    do_run("busy_edge", 1, 2);
    busy_len = 3;

    // Early abort: AL_DONE already set when CHK samples it.
    saw_cmpl = 1'b0;
    base = exec_count;
    exp_q.push_back(CNT_W'(7));
    FIRST_ADDR = 6'd7; LAST_ADDR = 6'd20; START = 1'b1;
    tick();
    tick();
    check_eq("abort_exec", 32'(EXECUTE), 32'd1);
    AL_DONE = 1'b1;
    wait_for("abort", SEL_ABORT, 20);
    check_eq("abort_exec_count", 32'(exec_count - base), 32'd1);
    check_eq("abort_no_cmpl", 32'(saw_cmpl), 32'd0);
    START = 1'b0; AL_DONE = 1'b0;
    tick();
    check_eq("abort_exit", 32'(ABORTED), 32'd0);
    check_eq("abort_exit_ena", 32'(AL_ENA), 32'd0);

    // Stuck BUSY: timeout lands on the 8th W_FIRST cycle.
    busy_stuck = 1'b1;
    base = exec_count;
    exp_q.push_back(CNT_W'(0));
    FIRST_ADDR = 6'd0; LAST_ADDR = 6'd3; START = 1'b1;
    tick();
    tick();
    n = 0;
    while (!TIMEOUT && (n < 40)) begin
      tick();
      n++;
    end
    check_eq("to_cycles_after_exec", 32'(n), 32'd9);
    check_eq("to_level", 32'(TIMEOUT), 32'd1);
    repeat (3) tick();
    check_eq("to_exec_count", 32'(exec_count - base), 32'd1);
    check_eq("to_no_cmpl", 32'(COMPLETED), 32'd0);
    START = 1'b0;
    busy_stuck = 1'b0;
    tick();
    check_eq("to_exit", 32'(TIMEOUT), 32'd0);
    check_eq("to_exit_ena", 32'(AL_ENA), 32'd0);

    // Reset pulse in W_RD at address 12, then a clean restart.
    push_range(10, 12, n);
    FIRST_ADDR = 6'd10; LAST_ADDR = 6'd20; START = 1'b1;
    n = 0;
    while (!(EXECUTE && (AL_CNT == 6'd12)) && (n < 100)) begin
      tick();
      n++;
    end
    check_eq("rst_mid_reach12", 32'(EXECUTE && (AL_CNT == 6'd12)), 32'd1);
    tick();
    RST = 1'b1;
    #1;
    check_eq("rst_mid_ena", 32'(AL_ENA), 32'd0);
    check_eq("rst_mid_exec", 32'(EXECUTE), 32'd0);
    check_eq("rst_mid_cnt", 32'(AL_CNT), 32'd0);
    check_eq("rst_mid_cmpl", 32'(COMPLETED), 32'd0);
    START = 1'b0;
    tick();
    RST = 1'b0;
    tick();
    do_run("restart", 10, 20);

    // START dropped and range inputs changed mid-run: latched range wins.
    base = exec_count;
    push_range(3, 6, n);
    FIRST_ADDR = 6'd3; LAST_ADDR = 6'd6; START = 1'b1;
    tick();
    tick();
    START = 1'b0; LAST_ADDR = 6'd2; FIRST_ADDR = 6'd40;
    wait_for("latched", SEL_CMPL, 60);
    check_eq("latched_exec_count", 32'(exec_count - base), 32'd4);
    check_eq("latched_final_cnt", 32'(AL_CNT), 32'd6);
    AL_DONE = 1'b1;
    tick();
    check_eq("latched_hold", 32'(COMPLETED), 32'd1);
    AL_DONE = 1'b0;
    tick();
    check_eq("latched_idle", 32'(AL_ENA), 32'd0);

    repeat (2) tick();
    check_eq("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
